// File: rtl/cordic_request_arbiter.sv
// rtl/cordic_request_arbiter.sv - round-robin arbiter feeding one CORDIC tick engine
// Two held requesters share the engine; WAIT is bounded by a timeout that aborts to IDLE.
module cordic_request_arbiter #(
  parameter int THETA_W   = 12,
  parameter int TICKS_W   = 19,
  parameter int TIMEOUT_P = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               edge_req_i,
  input  logic [THETA_W-1:0] edge_theta_i,
  input  logic               iter_req_i,
  input  logic [THETA_W-1:0] iter_theta_i,
  output logic               edge_gnt_o,
  output logic               iter_gnt_o,
  output logic               eng_valid_o,
  output logic [THETA_W-1:0] eng_theta_o,
  input  logic               eng_done_i,
  input  logic [TICKS_W-1:0] eng_ticks_i,
  output logic               result_valid_o,
  output logic [TICKS_W-1:0] result_ticks_o,
  output logic               result_src_o,
  output logic               busy_o,
  output logic               timeout_o,
  input  logic               timeout_clr_i
);

  localparam logic [15:0] LP_LAST_CNT = 16'(TIMEOUT_P - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             r_state;
  logic               r_src;
  logic               r_last_src;
  logic [15:0]        r_cnt;
  logic               r_edge_gnt;
  logic               r_iter_gnt;
  logic               r_eng_valid;
  logic [THETA_W-1:0] r_eng_theta;
  logic               r_result_valid;
  logic [TICKS_W-1:0] r_result_ticks;
  logic               r_result_src;
  logic               r_busy;
  logic               r_timeout;

  logic               w_any_req;
  logic               w_pick_iter;

  // Iter wins when it is alone, or when both request and edge was served last.
  assign w_any_req   = edge_req_i | iter_req_i;
  assign w_pick_iter = iter_req_i & (~edge_req_i | ~r_last_src);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_src          <= 1'b0;
      r_last_src     <= 1'b1;
      r_cnt          <= 16'd0;
      r_edge_gnt     <= 1'b0;
      r_iter_gnt     <= 1'b0;
      r_eng_valid    <= 1'b0;
      r_eng_theta    <= '0;
      r_result_valid <= 1'b0;
      r_result_ticks <= '0;
      r_result_src   <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_edge_gnt     <= 1'b0;
      r_iter_gnt     <= 1'b0;
      r_eng_valid    <= 1'b0;
      r_result_valid <= 1'b0;
      // A timeout set later in this block overrides a same-cycle clear.
      if (timeout_clr_i) begin
        r_timeout <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state     <= ST_ISSUE;
            r_busy      <= 1'b1;
            r_src       <= w_pick_iter;
            r_eng_theta <= w_pick_iter ? iter_theta_i : edge_theta_i;
            r_edge_gnt  <= ~w_pick_iter;
            r_iter_gnt  <= w_pick_iter;
            r_eng_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_last_src <= r_src;
          r_cnt      <= 16'd0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done_i) begin
            r_result_ticks <= eng_ticks_i;
            r_result_src   <= r_src;
            r_result_valid <= 1'b1;
            r_state        <= ST_RESP;
          end else if (r_cnt == LP_LAST_CNT) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_RESP: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign edge_gnt_o     = r_edge_gnt;
  assign iter_gnt_o     = r_iter_gnt;
  assign eng_valid_o    = r_eng_valid;
  assign eng_theta_o    = r_eng_theta;
  assign result_valid_o = r_result_valid;
  assign result_ticks_o = r_result_ticks;
  assign result_src_o   = r_result_src;
  assign busy_o         = r_busy;
  assign timeout_o      = r_timeout;

endmodule

// File: doc/cordic_request_arbiter.md
CORDIC_REQUEST_ARBITER -- requirements
Module: cordic_request_arbiter

Interface
REQ-001 Parameter THETA_W, default 12, iteration-index width.
REQ-002 Parameter TICKS_W, default 19, tick-result width.
REQ-003 Parameter TIMEOUT_P, default 255, maximum WAIT cycles before abort (1..65535).
REQ-004 clk_i  in  1  single clock; all logic is rising-edge clocked.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 edge_req_i  in  1  edge-theta requester asserts a request, held until grant.
REQ-007 edge_theta_i  in  THETA_W  edge iteration index, stable while edge_req_i is high.
REQ-008 iter_req_i  in  1  non-sequential iteration requester asserts a request, held until grant.
REQ-009 iter_theta_i  in  THETA_W  iteration index, stable while iter_req_i is high.
REQ-010 edge_gnt_o / iter_gnt_o  out  1 each  one-cycle grant pulse to the served requester.
REQ-011 eng_valid_o  out  1  one-cycle start pulse to the CORDIC tick engine.
REQ-012 eng_theta_o  out  THETA_W  captured index presented to the engine.
REQ-013 eng_done_i  in  1  engine result-valid pulse.
REQ-014 eng_ticks_i  in  TICKS_W  engine result, valid with eng_done_i.
REQ-015 result_valid_o  out  1  one-cycle result pulse.
REQ-016 result_ticks_o  out  TICKS_W  registered result.
REQ-017 result_src_o  out  1  0 = edge requester, 1 = iter requester.
REQ-018 busy_o  out  1  high in any state other than IDLE.
REQ-019 timeout_o  out  1  sticky abort flag.
REQ-020 timeout_clr_i  in  1  synchronous clear of timeout_o.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: if any request is sampled high, the FSM moves to ISSUE, latching the winning index into eng_theta_o and the source into an internal src register; otherwise it stays in IDLE.
REQ-023 Arbitration is round-robin: with both requests high, the source not served last wins; last_src resets to 1, so edge wins the first contention.
REQ-024 With a single request high, that source wins regardless of last_src.
REQ-025 ISSUE lasts exactly one cycle: eng_valid_o=1 and the matching gnt pulse=1; last_src is updated; the next state is WAIT.
REQ-026 Latency: a request sampled at edge N gives grant and eng_valid_o during cycle N+1.
REQ-027 WAIT: a 16-bit counter increments each cycle from 0; on eng_done_i the FSM captures eng_ticks_i into result_ticks_o and moves to RESP.
REQ-028 WAIT with counter = TIMEOUT_P-1 and no eng_done_i: the FSM sets timeout_o, goes to IDLE, and gives no result_valid_o for that request.
REQ-029 If eng_done_i and the timeout condition occur in the same cycle, done wins.
REQ-030 RESP lasts one cycle: result_valid_o=1, result_src_o=src; the next state is IDLE.
REQ-031 eng_done_i outside WAIT is ignored and does not change any output.
REQ-032 The minimum request-to-request throughput is 4 cycles (IDLE, ISSUE, WAIT≥1, RESP).
REQ-033 The arbiter never grants while busy; requests raised while busy are held by the requesters and are evaluated on return to IDLE.
REQ-034 Requesters must deassert their request the cycle after the grant; a request still high at the next IDLE is treated as a new request.
REQ-035 timeout_clr_i clears timeout_o; if the clear and a new timeout occur in the same cycle, the set wins.
REQ-036 result_ticks_o and result_src_o hold their values between results.

Reset
REQ-037 On rst_i: state=IDLE, all pulse outputs=0, busy_o=0, timeout_o=0, eng_theta_o=0, result_ticks_o=0, result_src_o=0, last_src=1, counter=0.
REQ-038 rst_i during WAIT aborts the transaction with no result_valid_o and no timeout_o; after release, requests are arbitrated again.

Verification
REQ-039 Single edge request, edge_theta_i=1795, engine done 10 cycles after eng_valid_o with ticks 0x1A2B3 -> edge_gnt_o at N+1, eng_theta_o=1795, result_valid_o with result_ticks_o=0x1A2B3 and result_src_o=0.
REQ-040 Both requests held continuously for 4 transactions -> grant order edge, iter, edge, iter.
REQ-041 Iter request, engine never responds, TIMEOUT_P=8 -> timeout_o rises 8 cycles into WAIT, no result_valid_o, then busy_o=0; timeout_clr_i pulse -> timeout_o=0.
REQ-042 Spurious eng_done_i while in IDLE, and eng_done_i coincident with the last timeout cycle -> first ignored; second produces a result and leaves timeout_o=0.
REQ-043 rst_i asserted mid-WAIT, then an iter request -> all outputs at reset values immediately; the next transaction completes normally with result_src_o=1.
